// File: rtl/y86_alu_pkg.sv
// Shared Y86 ALU definitions: OPq function codes and the sequential
// add/sub controller state encoding.
package y86_alu_pkg;

   localparam logic [3:0] ALU_ADD = 4'h0;
   localparam logic [3:0] ALU_SUB = 4'h1;
   localparam logic [3:0] ALU_AND = 4'h2;
   localparam logic [3:0] ALU_XOR = 4'h3;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   function automatic logic is_legal(input logic [3:0] sel);
      return sel <= ALU_XOR;
   endfunction

endpackage

// File: rtl/add_sub_slice.sv
// One CHUNK-bit combinational ALU stage; the top reuses it once per step.
// Illegal function codes produce zero sum and zero carry.
module add_sub_slice
   import y86_alu_pkg::*;
#(
   parameter int CHUNK = 16
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   input  logic [3:0]       sel,
   output logic [CHUNK-1:0] sum,
   output logic             cout
);

   logic [CHUNK-1:0] bx;
   logic [CHUNK:0]   full;

   always_comb begin
      bx   = (sel == ALU_SUB) ? ~b : b;
      full = {1'b0, a} + {1'b0, bx} + {{CHUNK{1'b0}}, cin};
      sum  = '0;
      cout = 1'b0;
      case (sel)
         ALU_ADD, ALU_SUB: begin
            sum  = full[CHUNK-1:0];
            cout = full[CHUNK];
         end
         ALU_AND: sum = a & b;
         ALU_XOR: sum = a ^ b;
         default: ;
      endcase
   end

endmodule

// File: rtl/seq_add_sub.sv
// Multi-cycle Y86 OPq unit: CHUNK bits per clock through a registered carry,
// with Y86 condition codes registered on entry to DONE.
module seq_add_sub
   import y86_alu_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int CHUNK = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       sel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zf,
   output logic             sf,
   output logic             of,
   output logic             cf,
   output logic             err
);

   localparam int NSTEP = WIDTH / CHUNK;
   localparam int KW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;

   // Handshake: a transfer happens on a rising edge where valid & ready are
   // both high; the source holds its data stable until then, ready never
   // depends on valid.
   state_t           state;
   logic [WIDTH-1:0] a_q, b_q;
   logic [3:0]       sel_q;
   logic             carry;
   logic [KW-1:0]    k;

   logic [31:0]      base;
   logic [CHUNK-1:0] op_a, op_b, s_sum;
   logic             s_cout;
   logic [WIDTH-1:0] slice_mask, next_result;
   logic             last, legal, arith, of_next;

   assign in_ready = (state == S_IDLE);

   assign base  = 32'(k) * 32'(CHUNK);
   assign op_a  = CHUNK'(a_q >> base);
   assign op_b  = CHUNK'(b_q >> base);
   assign last  = (k == KW'(NSTEP - 1));
   assign legal = is_legal(sel_q);
   assign arith = (sel_q == ALU_ADD) || (sel_q == ALU_SUB);

   add_sub_slice #(.CHUNK(CHUNK)) u_slice (
      .a    (op_a),
      .b    (op_b),
      .cin  (carry),
      .sel  (sel_q),
      .sum  (s_sum),
      .cout (s_cout)
   );

   // Merge the current slice into the result; on the last step this is the
   // full value the flags are derived from.
   always_comb begin
      slice_mask  = WIDTH'({CHUNK{1'b1}}) << base;
      next_result = (result & ~slice_mask) | (WIDTH'(s_sum) << base);
      of_next     = 1'b0;
      case (sel_q)
         ALU_ADD: of_next = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                            (next_result[WIDTH-1] != a_q[WIDTH-1]);
         ALU_SUB: of_next = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                            (next_result[WIDTH-1] != a_q[WIDTH-1]);
         default: of_next = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         out_valid <= 1'b0;
         result    <= '0;
         zf        <= 1'b0;
         sf        <= 1'b0;
         of        <= 1'b0;
         cf        <= 1'b0;
         err       <= 1'b0;
         k         <= '0;
         carry     <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         sel_q     <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  a_q   <= a;
                  b_q   <= b;
                  sel_q <= sel;
                  carry <= ~sel[1] & sel[0];
                  k     <= '0;
                  state <= S_BUSY;
               end
            end
            S_BUSY: begin
               result <= next_result;
               carry  <= s_cout;
               k      <= k + KW'(1);
               if (last) begin
                  state     <= S_DONE;
                  out_valid <= 1'b1;
                  zf        <= legal && (next_result == '0);
                  sf        <= legal && next_result[WIDTH-1];
                  of        <= of_next;
                  cf        <= arith && s_cout;
                  err       <= !legal;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  state     <= S_IDLE;
                  out_valid <= 1'b0;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_add_sub.sv
// Bench for seq_add_sub: 64/16 instance checked every cycle against an
// arithmetic model, plus three WIDTH=8 instances for the CHUNK sweep.
module tb_seq_add_sub;
   import y86_alu_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- main DUT ----------------
   logic        in_valid = 1'b0, out_ready = 1'b1;
   logic        in_ready, out_valid;
   logic [63:0] a = '0, b = '0, result;
   logic [3:0]  sel = '0;
   logic        zf, sf, of, cf, err;

   seq_add_sub #(.WIDTH(64), .CHUNK(16)) u_dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .zf(zf), .sf(sf), .of(of), .cf(cf), .err(err)
   );

   // ---------------- WIDTH=8 sweep DUTs (CHUNK 1, 4, 8) ----------------
   logic       iv8 = 1'b0, or8 = 1'b1;
   logic [7:0] a8 = '0, b8 = '0;
   logic [3:0] sel8 = '0;
   logic       ir8[3], ov8[3], zf8[3], sf8[3], of8[3], cf8[3], err8[3];
   logic [7:0] r8[3];

   for (genvar g = 0; g < 3; g++) begin : g_sweep
      seq_add_sub #(.WIDTH(8), .CHUNK((g == 0) ? 1 : (g == 1) ? 4 : 8)) u8 (
         .clk(clk), .reset(reset), .in_valid(iv8), .in_ready(ir8[g]),
         .a(a8), .b(b8), .sel(sel8), .out_valid(ov8[g]), .out_ready(or8),
         .result(r8[g]), .zf(zf8[g]), .sf(sf8[g]), .of(of8[g]), .cf(cf8[g]),
         .err(err8[g])
      );
   end

   // ---------------- checking ----------------
   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [68:0] act, input logic [68:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Reference: {err, cf, of, sf, zf, result} from true integer arithmetic.
   function automatic logic [68:0] model(input logic [63:0] x, input logic [63:0] y,
                                         input logic [3:0] s, input int w);
      logic [64:0] mask, full;
      logic [63:0] r;
      logic signed [67:0] sx, sy, tv, lim;
      logic zf_m, sf_m, of_m, cf_m, err_m;
      mask = (65'd1 << w) - 65'd1;
      sx = $signed({4'b0, x});
      sy = $signed({4'b0, y});
      if (x[w-1]) sx = sx - (68'sd1 <<< w);
      if (y[w-1]) sy = sy - (68'sd1 <<< w);
      lim = 68'sd1 <<< (w - 1);
      err_m = 1'b0; cf_m = 1'b0; of_m = 1'b0; tv = '0;
      case (s)
         ALU_ADD: begin
            full = {1'b0, x} + {1'b0, y};
            tv = sx + sy; cf_m = full[w]; of_m = (tv >= lim) || (tv < -lim);
         end
         ALU_SUB: begin
            full = {1'b0, x} + ({1'b0, ~y} & mask) + 65'd1;
            tv = sx - sy; cf_m = full[w]; of_m = (tv >= lim) || (tv < -lim);
         end
         ALU_AND: full = {1'b0, x & y};
         ALU_XOR: full = {1'b0, x ^ y};
         default: begin full = '0; err_m = 1'b1; end
      endcase
      r = full[63:0] & mask[63:0];
      zf_m = (r == 64'd0) && !err_m;
      sf_m = r[w-1];
      return {err_m, cf_m, of_m, sf_m, zf_m, r};
   endfunction

   // Scoreboard: expected outcome and transfer cycle per accepted operation.
   logic [68:0] exp_q[$];
   int          t_q[$];
   bit          seen_first = 1'b0;

   always @(negedge clk) begin
      if (reset) begin
         exp_q.delete();
         t_q.delete();
         seen_first = 1'b0;
      end else begin
         chk("in_ready idle", in_ready, exp_q.size() == 0);
         if (in_valid && in_ready) begin
            exp_q.push_back(model(a, b, sel, 64));
            t_q.push_back(cyc + 1);
         end
         if (out_valid) begin
            if (exp_q.size() == 0) chk("unexpected out_valid", 1, 0);
            else begin
               chk("result/flags", {err, cf, of, sf, zf, result}, exp_q[0]);
               if (!seen_first) begin
                  chk("latency", cyc - t_q[0], 4);
                  seen_first = 1'b1;
               end
               if (out_ready) begin
                  void'(exp_q.pop_front());
                  void'(t_q.pop_front());
                  seen_first = 1'b0;
               end
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic chk_reset_state(input string nm);
      @(negedge clk);
      chk({nm, " in_ready"}, in_ready, 1);
      chk({nm, " out_valid"}, out_valid, 0);
      chk({nm, " outputs"}, {err, cf, of, sf, zf, result}, 69'd0);
   endtask

   task automatic wait_hs();
      int n = 0;
      @(negedge clk);
      while (!(out_valid && out_ready) && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (n >= 50) chk("handshake timeout", 1, 0);
      @(posedge clk); #1;
   endtask

   task automatic run_op(input logic [63:0] av, input logic [63:0] bv, input logic [3:0] s);
      int n = 0;
      a = av; b = bv; sel = s; in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (n >= 50) chk("accept timeout", 1, 0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_hs();
   endtask

   task automatic sweep_one(input logic [7:0] av, input logic [7:0] bv, input logic [3:0] s);
      logic [68:0] e;
      bit seen[3];
      int lat_exp[3];
      lat_exp = '{8, 2, 1};
      seen = '{1'b0, 1'b0, 1'b0};
      e = model({56'd0, av}, {56'd0, bv}, s, 8);
      a8 = av; b8 = bv; sel8 = s; iv8 = 1'b1;
      @(posedge clk); #1;
      iv8 = 1'b0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         for (int g = 0; g < 3; g++) begin
            if (ov8[g] && !seen[g]) begin
               seen[g] = 1'b1;
               chk($sformatf("sweep%0d latency", g), c, lat_exp[g]);
               chk($sformatf("sweep%0d result", g),
                   {err8[g], cf8[g], of8[g], sf8[g], zf8[g], 56'd0, r8[g]}, e);
            end
         end
      end
      for (int g = 0; g < 3; g++) chk($sformatf("sweep%0d done", g), seen[g], 1);
      @(posedge clk); #1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      chk_reset_state("reset");

      // Pin the reference model with hand-computed values.
      chk("pin add wrap", model(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, ALU_ADD, 64),
          {5'b01001, 64'h0});
      chk("pin add ovf", model(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, ALU_ADD, 64),
          {5'b00110, 64'h8000_0000_0000_0000});
      chk("pin sub eq", model(64'h5, 64'h5, ALU_SUB, 64), {5'b01001, 64'h0});
      chk("pin sub ovf", model(64'h8000_0000_0000_0000, 64'h1, ALU_SUB, 64),
          {5'b01100, 64'h7FFF_FFFF_FFFF_FFFF});
      chk("pin and", model(64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, ALU_AND, 64),
          {5'b00010, 64'hF000_F000_F000_F000});
      chk("pin illegal", model(64'h1234, 64'h5678, 4'h7, 64), {5'b10000, 64'h0});
      chk("pin sub8 borrow", model(64'h3, 64'h5, ALU_SUB, 8), {5'b00010, 64'hFE});

      // Reset in the middle of BUSY aborts the operation.
      a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'h1; sel = ALU_ADD; in_valid = 1'b1;
      @(posedge clk); #1 in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      chk_reset_state("mid-busy reset");

      run_op(64'h1, 64'h2, ALU_ADD);
      run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, ALU_ADD);
      run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, ALU_ADD);
      run_op(64'h5, 64'h5, ALU_SUB);
      run_op(64'h8000_0000_0000_0000, 64'h1, ALU_SUB);
      run_op(64'h3, 64'h5, ALU_SUB);
      run_op(64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, ALU_AND);
      run_op(64'h1234, 64'h1234, ALU_XOR);
      run_op(64'h1234, 64'h5678, 4'h7);
      run_op(64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, ALU_ADD);

      // Backpressure: hold DONE for 10 cycles while pulsing in_valid.
      out_ready = 1'b0;
      a = 64'h0123_4567_89AB_CDEF; b = 64'h1111_1111_1111_1111; sel = ALU_SUB;
      in_valid = 1'b1;
      @(posedge clk); #1 in_valid = 1'b0;
      begin
         int n = 0;
         @(negedge clk);
         while (!out_valid && n < 20) begin
            n++;
            @(negedge clk);
         end
         if (n >= 20) chk("bp out_valid timeout", 1, 0);
      end
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         in_valid = i[0];
         a = {$urandom, $urandom}; b = {$urandom, $urandom}; sel = ALU_ADD;
         @(negedge clk);
         chk("bp in_ready", in_ready, 0);
         chk("bp out_valid", out_valid, 1);
      end
      @(posedge clk); #1;
      a = 64'd10; b = 64'd20; sel = ALU_ADD; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp ready after handshake", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("bp next accepted", in_ready, 0);
      wait_hs();

      // Parameter sweep at WIDTH=8.
      sweep_one(8'hFF, 8'h01, ALU_ADD);
      sweep_one(8'h80, 8'h01, ALU_SUB);
      sweep_one(8'h7F, 8'h01, ALU_ADD);
      sweep_one(8'h03, 8'h05, ALU_SUB);
      for (int i = 0; i < 6; i++)
         sweep_one(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                   4'($urandom_range(0, 1)));

      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
